umultadd_acc: RTL and testbench

//  Downstream accumulator for the umultadd multiply-add pipeline. Sums a framed stream of
//  (DWIDTH*2+1)-bit products into a guarded accumulator and presents one result per frame
//  (dot product / FIR output) on a single-entry valid/ready output register.

---
 rtl/umultadd_acc.sv | 100 ++++++++++
 tb/tb_umultadd_acc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/umultadd_acc.sv
// Frame accumulator for the umultadd pipeline: saturating sum of a framed product stream,
// one result per frame presented on a single-entry valid/ready output register.
module umultadd_acc #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned GUARD   = 8,
    parameter int unsigned MAX_LEN = 256,
    localparam int unsigned INW    = DWIDTH * 2 + 1,
    localparam int unsigned ACCW   = INW + GUARD,
    localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            sclr,
    input  logic            in_valid,
    input  logic [INW-1:0]  in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic [CW-1:0]   out_count,
    output logic            out_ovf,
    output logic            out_len_err
);

    typedef enum logic {StIdle, StAcc} state_t;

    state_t          state_q;
    logic [ACCW-1:0] acc_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;

    logic            accept;
    logic [ACCW-1:0] base_acc;
    logic [CW-1:0]   base_cnt;
    logic            base_ovf;
    logic [ACCW:0]   sum;
    logic            carry;
    logic [ACCW-1:0] new_acc;
    logic [CW-1:0]   new_cnt;
    logic            new_ovf;
    logic            close;

    // A pending result that is not being drained this cycle blocks new terms.
    assign in_ready = !sclr && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        base_acc = '0;
        base_cnt = '0;
        base_ovf = 1'b0;
        if (state_q == StAcc) begin
            base_acc = acc_q;
            base_cnt = cnt_q;
            base_ovf = ovf_q;
        end
        sum     = {1'b0, base_acc} + {{(GUARD + 1){1'b0}}, in_data};
        carry   = sum[ACCW];
        new_acc = carry ? {ACCW{1'b1}} : sum[ACCW-1:0];
        new_cnt = base_cnt + CW'(1);
        new_ovf = base_ovf | carry;
        close   = in_last || (new_cnt == CW'(MAX_LEN));
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_count   <= '0;
            out_ovf     <= 1'b0;
            out_len_err <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (close) begin
                    state_q     <= StIdle;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                    out_valid   <= 1'b1;
                    out_data    <= new_acc;
                    out_count   <= new_cnt;
                    out_ovf     <= new_ovf;
                    out_len_err <= !in_last;
                end else begin
                    state_q <= StAcc;
                    acc_q   <= new_acc;
                    cnt_q   <= new_cnt;
                    ovf_q   <= new_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_umultadd_acc.sv
// Directed self-checking bench for umultadd_acc (GUARD=0, MAX_LEN=4 so saturation and
// forced frame closure are reachable with short vectors).
module tb_umultadd_acc;

    localparam int unsigned DWIDTH  = 16;
    localparam int unsigned GUARD   = 0;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned INW     = DWIDTH * 2 + 1;
    localparam int unsigned ACCW    = INW + GUARD;
    localparam int unsigned CW      = $clog2(MAX_LEN + 1);

    logic            clk = 1'b0;
    logic            sclr;
    logic            in_valid;
    logic [INW-1:0]  in_data;
    logic            in_last;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;
    logic [CW-1:0]   out_count;
    logic            out_ovf;
    logic            out_len_err;

    int checks   = 0;
    int failures = 0;

    umultadd_acc #(
        .DWIDTH (DWIDTH),
        .GUARD  (GUARD),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk        (clk),
        .sclr       (sclr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_ovf    (out_ovf),
        .out_len_err(out_len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [INW-1:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [ACCW-1:0] d, input logic [CW-1:0] c,
                           input logic o, input logic e);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(d));
        chk({tag, "_count"}, 64'(out_count), 64'(c));
        chk({tag, "_ovf"}, 64'(out_ovf), 64'(o));
        chk({tag, "_len_err"}, 64'(out_len_err), 64'(e));
    endtask

    initial begin
        sclr      = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, '0, 1'b0);
        cyc();
        cyc();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_out_len_err", 64'(out_len_err), 64'd0);
        sclr = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 1: four-term frame, closed by in_last exactly at MAX_LEN
        out_ready = 1'b1;
        drive(1'b1, 33'd1, 1'b0); cyc();
        drive(1'b1, 33'd2, 1'b0); cyc();
        drive(1'b1, 33'd3, 1'b0); cyc();
        chk("t1_no_early_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 33'd4, 1'b1);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        cyc();
        chk_res("t1", 33'd10, 3'd4, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0); cyc();
        chk("t1_drained", 64'(out_valid), 64'd0);

        // 2: backpressure holds the result and stalls input
        out_ready = 1'b0;
        drive(1'b1, 33'd5, 1'b1); cyc();
        chk_res("t2a", 33'd5, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 33'd6, 1'b0);
        chk("t2_stall_ready", 64'(in_ready), 64'd0);
        cyc();
        chk("t2_hold_valid", 64'(out_valid), 64'd1);
        chk("t2_hold_data", 64'(out_data), 64'd5);
        chk("t2_stall_ready2", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("t2_release_ready", 64'(in_ready), 64'd1);
        cyc();
        chk("t2_drained", 64'(out_valid), 64'd0);
        drive(1'b1, 33'd7, 1'b1); cyc();
        chk_res("t2b", 33'd13, 3'd2, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0); cyc();
        chk("t2_idle", 64'(out_valid), 64'd0);

        // 3: saturation and its per-frame clearing
        drive(1'b1, 33'h1_FFFC_0002, 1'b0); cyc();
        drive(1'b1, 33'h1_FFFC_0002, 1'b1); cyc();
        chk_res("t3a", 33'h1_FFFF_FFFF, 3'd2, 1'b1, 1'b0);
        drive(1'b1, 33'd1, 1'b1); cyc();
        chk_res("t3b", 33'd1, 3'd1, 1'b0, 1'b0);
        // ovf stays set and the sum stays pinned after the carry
        drive(1'b1, 33'h1_FFFF_FFFF, 1'b0); cyc();
        drive(1'b1, 33'd1, 1'b0); cyc();
        drive(1'b1, 33'd0, 1'b1); cyc();
        chk_res("t3c", 33'h1_FFFF_FFFF, 3'd3, 1'b1, 1'b0);

        // 4: frame force-closed at MAX_LEN, remainder forms a new frame
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 33'd1, 1'b0);
            cyc();
        end
        chk_res("t4a", 33'd4, 3'd4, 1'b0, 1'b1);
        drive(1'b1, 33'd1, 1'b0); cyc();
        chk("t4_mid_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 33'd1, 1'b1); cyc();
        chk_res("t4b", 33'd2, 3'd2, 1'b0, 1'b0);

        // 5: reset drops a partial frame and ignores a concurrent beat
        drive(1'b1, 33'd7, 1'b0); cyc();
        drive(1'b1, 33'd7, 1'b0); cyc();
        chk("t5_partial_valid", 64'(out_valid), 64'd0);
        sclr = 1'b1;
        drive(1'b1, 33'd9, 1'b1);
        chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
        cyc();
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        sclr = 1'b0;
        drive(1'b1, 33'd3, 1'b1); cyc();
        chk_res("t5", 33'd3, 3'd1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0); cyc();
        chk("t5_idle", 64'(out_valid), 64'd0);

        // 6: back-to-back single-term frames at full rate
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 33'(i), 1'b1);
            chk("t6_in_ready", 64'(in_ready), 64'd1);
            cyc();
            chk("t6_valid", 64'(out_valid), 64'd1);
            chk("t6_data", 64'(out_data), 64'(i));
        end
        drive(1'b0, '0, 1'b0); cyc();
        chk("t6_end_valid", 64'(out_valid), 64'd0);
        chk("t6_end_data_kept", 64'(out_data), 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
